akiko_p2c: RTL and testbench

//  Planar-to-chunky converter in the Akiko register space ($B8xxxx), the reverse of the C2P path.
//  CPU writes up to 8 bitplane words of 16 pixels, then reads 8 words of chunky data, two 8-bit

---
 rtl/akiko_pkg.sv | 13 +
 rtl/akiko_p2c_gather.sv | 32 +++
 rtl/akiko_p2c.sv | 167 ++++++++++++++++
 tb/tb_akiko_p2c.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/akiko_pkg.sv
// Shared types and defaults for the Akiko planar-to-chunky converter.
package akiko_pkg;

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam int unsigned MAX_PLANES   = 8;
  localparam logic [5:0]  DEF_DATA_OFS = 6'h0F;
  localparam logic [5:0]  DEF_STAT_OFS = 6'h10;

endpackage

// File: rtl/akiko_p2c_gather.sv
// Combinational gather: picks pixel pair rdptr out of the captured planes and
// packs it into one 16-bit chunky word (even pixel in the high byte).
module akiko_p2c_gather
  import akiko_pkg::*;
#(
  parameter int unsigned PLANES = MAX_PLANES
) (
  input  logic [16*MAX_PLANES-1:0] planes,
  input  logic [2:0]               rdptr,
  output logic [15:0]              word
);

  logic [3:0] n_hi;
  logic [3:0] n_lo;

  assign n_hi = {rdptr, 1'b0};
  assign n_lo = {rdptr, 1'b1};

  // Pixel n lives at plane bit 15-n, which for a 4-bit n is simply ~n.
  for (genvar p = 0; p < MAX_PLANES; p++) begin : g_plane
    if (p < PLANES) begin : g_used
      logic [15:0] pw;
      assign pw        = planes[p*16 +: 16];
      assign word[8+p] = pw[~n_hi];
      assign word[p]   = pw[~n_lo];
    end else begin : g_unused
      assign word[8+p] = 1'b0;
      assign word[p]   = 1'b0;
    end
  end

endmodule

// File: rtl/akiko_p2c.sv
// Akiko planar-to-chunky converter. CPU writes bitplane words to the data
// register, then reads back chunky pixel pairs from the same register.
// Optional status register at STAT_OFS when AKIKO_P2C_STATUS_EN is defined.
module akiko_p2c
  import akiko_pkg::*;
#(
  parameter int unsigned PLANES   = MAX_PLANES,
  parameter logic [5:0]  DATA_OFS = DEF_DATA_OFS
`ifdef AKIKO_P2C_STATUS_EN
  ,
  parameter logic [5:0]  STAT_OFS = DEF_STAT_OFS
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:1] address_in,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        rd,
  input  logic        hwr,
  input  logic        lwr,
  input  logic        sel_akiko
);

  localparam logic [2:0] LAST_PLANE    = 3'(PLANES - 1);
  localparam logic [2:0] RESTART_PTR   = (PLANES == 1) ? 3'd0 : 3'd1;
  localparam state_t     RESTART_STATE = (PLANES == 1) ? S_DRAIN : S_LOAD;

  logic        sel_d;
  logic        wstb;
  logic        rstb;
  logic        wstb_q;
  logic        rstb_q;
  logic        wr_armed_q;
  logic        wr_edge;
  logic        rd_edge;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  wrptr_q;
  logic [2:0]  wrptr_d;
  logic [2:0]  rdptr_q;
  logic [2:0]  rdptr_d;

  logic        plane_we;
  logic [2:0]  plane_idx;
  logic [15:0] plane_q [MAX_PLANES];
  logic [16*MAX_PLANES-1:0] planes_flat;
  logic [15:0] word;

  logic        unused_addr;
  assign unused_addr = ^{address_in[23:8], address_in[1]};

  assign sel_d = sel_akiko && (address_in[7:2] == DATA_OFS);
  assign wstb  = sel_d && hwr && lwr;
  assign rstb  = sel_d && rd;

  // A strobe already high when reset releases must not count as a rising edge,
  // so writes are only armed once the strobe has been seen low.
  assign wr_edge = wstb && !wstb_q && wr_armed_q;
  assign rd_edge = !rstb && rstb_q;

  // Strobe history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstb_q     <= 1'b0;
      rstb_q     <= 1'b0;
      wr_armed_q <= 1'b0;
    end else begin
      wstb_q     <= wstb;
      rstb_q     <= rstb;
      wr_armed_q <= wr_armed_q || !wstb;
    end
  end

  // FSM and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      wrptr_q <= 3'd0;
      rdptr_q <= 3'd0;
    end else begin
      state_q <= state_d;
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
    end
  end

  // Next-state: a write edge takes priority and drops any coincident read advance.
  always_comb begin
    state_d   = state_q;
    wrptr_d   = wrptr_q;
    rdptr_d   = rdptr_q;
    plane_we  = 1'b0;
    plane_idx = wrptr_q;
    if (wr_edge) begin
      plane_we = 1'b1;
      unique case (state_q)
        S_LOAD: begin
          if (wrptr_q == LAST_PLANE) begin
            wrptr_d = 3'd0;
            rdptr_d = 3'd0;
            state_d = S_DRAIN;
          end else begin
            wrptr_d = wrptr_q + 3'd1;
          end
        end
        S_DRAIN: begin
          plane_idx = 3'd0;
          wrptr_d   = RESTART_PTR;
          rdptr_d   = 3'd0;
          state_d   = RESTART_STATE;
        end
      endcase
    end else if (rd_edge) begin
      rdptr_d = rdptr_q + 3'd1;
      wrptr_d = 3'd0;
      state_d = S_DRAIN;
    end
  end

  // Plane capture registers; planes not rewritten keep their old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PLANES; i++) begin
        plane_q[i] <= 16'h0000;
      end
    end else if (plane_we) begin
      plane_q[plane_idx] <= data_in;
    end
  end

  // Flatten planes for the gather block.
  always_comb begin
    planes_flat = '0;
    for (int i = 0; i < MAX_PLANES; i++) begin
      planes_flat[i*16 +: 16] = plane_q[i];
    end
  end

  akiko_p2c_gather #(
    .PLANES(PLANES)
  ) u_gather (
    .planes(planes_flat),
    .rdptr (rdptr_q),
    .word  (word)
  );

`ifdef AKIKO_P2C_STATUS_EN
  logic stat_rd;
  assign stat_rd = sel_akiko && (address_in[7:2] == STAT_OFS) && rd;
`endif

  // Read mux: zero when not selected so it can be ORed into the CPU data bus.
  always_comb begin
    data_out = 16'h0000;
    if (rstb) begin
      data_out = word;
    end
`ifdef AKIKO_P2C_STATUS_EN
    if (stat_rd) begin
      data_out = {12'h000, state_q == S_DRAIN, rdptr_q};
    end
`endif
  end

endmodule

// File: tb/tb_akiko_p2c.sv
// Directed self-checking bench for akiko_p2c.
module tb_akiko_p2c;

  logic        clk;
  logic        reset;
  logic [23:1] address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd;
  logic        hwr;
  logic        lwr;
  logic        sel_akiko;

  int total;
  int bad;

  localparam logic [23:0] DATA_ADDR = 24'hB8003C;
  localparam logic [23:0] STAT_ADDR = 24'hB80040;
  localparam logic [23:0] OTHER_ADDR = 24'hB80038;

  akiko_p2c dut (
    .clk       (clk),
    .reset     (reset),
    .address_in(address_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .rd        (rd),
    .hwr       (hwr),
    .lwr       (lwr),
    .sel_akiko (sel_akiko)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_addr(input logic [23:0] a);
    address_in = a[23:1];
  endtask

  task automatic bus_write(input logic [15:0] d, input logic hi, input logic lo);
    @(negedge clk);
    set_addr(DATA_ADDR);
    sel_akiko = 1'b1;
    data_in   = d;
    hwr       = hi;
    lwr       = lo;
    @(negedge clk);
    hwr = 1'b0;
    lwr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read_at(input logic [23:0] a, input logic sel, output logic [15:0] d);
    @(negedge clk);
    set_addr(a);
    sel_akiko = sel;
    rd        = 1'b1;
    @(negedge clk);
    d  = data_out;
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic load8(input logic [15:0] p0, input logic [15:0] rest, input logic shift);
    logic [15:0] v;
    for (int p = 0; p < 8; p++) begin
      if (shift) v = 16'h8000 >> p;
      else v = (p == 0) ? p0 : rest;
      bus_write(v, 1'b1, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    // Read held across reset: must return 0 and leave no edge behind.
    @(negedge clk);
    reset = 1'b1;
    set_addr(DATA_ADDR);
    sel_akiko = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    total++;
    if (data_out !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data_out: got %h want %h", data_out, 16'h0000);
    end
    rd = 1'b0;
    // Write strobe held high through reset release must be ignored.
    data_in = 16'h8000;
    hwr = 1'b1;
    lwr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    hwr = 1'b0;
    lwr = 1'b0;
    @(negedge clk);
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL reset_held_strobe: got %h want %h", d, 16'h0000);
    end
    do_reset();
  endtask

  task automatic test_single_pixel();
    logic [15:0] d;
    load8(16'h8000, 16'h0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus_read_at(DATA_ADDR, 1'b1, d);
      total++;
      if (d !== ((k == 0) ? 16'h0100 : 16'h0000)) begin
        bad++;
        $display("FAIL single_pixel_word%0d: got %h want %h", k, d,
                 (k == 0) ? 16'h0100 : 16'h0000);
      end
    end
  endtask

  task automatic test_all_ones();
    logic [15:0] d;
    load8(16'hFFFF, 16'hFFFF, 1'b0);
    bus_read_at(DATA_ADDR, 1'b0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL unselected_read: got %h want %h", d, 16'h0000);
    end
    bus_read_at(OTHER_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL other_offset_read: got %h want %h", d, 16'h0000);
    end
    for (int k = 0; k < 9; k++) begin
      bus_read_at(DATA_ADDR, 1'b1, d);
      total++;
      if (d !== 16'hFFFF) begin
        bad++;
        $display("FAIL all_ones_read%0d: got %h want %h", k, d, 16'hFFFF);
      end
    end
  endtask

  task automatic test_diagonal();
    logic [15:0] d;
    logic [15:0] exp [8];
    exp = '{16'h0102, 16'h0408, 16'h1020, 16'h4080,
            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    // After the 9 reads above the DUT is in drain; a write restarts at plane 0.
    load8(16'h0000, 16'h0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      bus_read_at(DATA_ADDR, 1'b1, d);
      total++;
      if (d !== exp[k]) begin
        bad++;
        $display("FAIL diagonal_word%0d: got %h want %h", k, d, exp[k]);
      end
    end
  endtask

  task automatic test_partial_load();
    logic [15:0] d;
    load8(16'h8000, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) bus_write(16'h0000, 1'b1, 1'b1);
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL partial_load_read: got %h want %h", d, 16'h0000);
    end
    // Now in drain: the next write must land in plane 0 and reset rdptr.
    bus_write(16'h8000, 1'b1, 1'b1);
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0100) begin
      bad++;
      $display("FAIL partial_next_plane0: got %h want %h", d, 16'h0100);
    end
  endtask

  task automatic test_hold_and_collision();
    logic [15:0] d;
    load8(16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    set_addr(DATA_ADDR);
    sel_akiko = 1'b1;
    rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (data_out !== 16'h0102) begin
        bad++;
        $display("FAIL hold_cycle%0d: got %h want %h", c, data_out, 16'h0102);
      end
    end
    rd = 1'b0;
    @(negedge clk);
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0408) begin
      bad++;
      $display("FAIL hold_advance_once: got %h want %h", d, 16'h0408);
    end
    // Drain-state write: plane0=FFFF, back to load with wrptr=1, rdptr=0.
    bus_write(16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    // Read falling edge and write rising edge in the same cycle.
    rd = 1'b0;
    data_in = 16'h0000;
    hwr = 1'b1;
    lwr = 1'b1;
    @(negedge clk);
    hwr = 1'b0;
    lwr = 1'b0;
    @(negedge clk);
    // plane1 cleared, rdptr still 0: word0 = {01, 01}.
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0101) begin
      bad++;
      $display("FAIL collision_write_wins: got %h want %h", d, 16'h0101);
    end
  endtask

  task automatic test_byte_write();
    logic [15:0] d;
    load8(16'h0000, 16'h0000, 1'b0);
    bus_write(16'hFFFF, 1'b1, 1'b0);
    bus_write(16'hFFFF, 1'b0, 1'b1);
    bus_read_at(DATA_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL byte_write_ignored: got %h want %h", d, 16'h0000);
    end
  endtask

  task automatic test_reset_midload();
    logic [15:0] d;
    for (int k = 0; k < 4; k++) bus_write(16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    set_addr(DATA_ADDR);
    sel_akiko = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    total++;
    if (data_out !== 16'h0000) begin
      bad++;
      $display("FAIL midload_reset_out: got %h want %h", data_out, 16'h0000);
    end
    rd = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    load8(16'h8000, 16'h0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      bus_read_at(DATA_ADDR, 1'b1, d);
      total++;
      if (d !== ((k == 0) ? 16'h0100 : 16'h0000)) begin
        bad++;
        $display("FAIL midload_reload_word%0d: got %h want %h", k, d,
                 (k == 0) ? 16'h0100 : 16'h0000);
      end
    end
`ifdef AKIKO_P2C_STATUS_EN
    load8(16'h8000, 16'h0000, 1'b0);
    bus_read_at(STAT_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0008) begin
      bad++;
      $display("FAIL status_after_load: got %h want %h", d, 16'h0008);
    end
`else
    bus_read_at(STAT_ADDR, 1'b1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL status_absent: got %h want %h", d, 16'h0000);
    end
`endif
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    address_in = '0;
    data_in    = '0;
    rd         = 1'b0;
    hwr        = 1'b0;
    lwr        = 1'b0;
    sel_akiko  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_pixel();
    test_all_ones();
    test_diagonal();
    test_partial_load();
    test_hold_and_collision();
    test_byte_write();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
